// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: receive-side parser for phone commands arriving over the
// Bluetooth UART link. It decodes frames of the form SYNC CMD LEN PAYLOAD CHK
// and drives the heart-rate cap and the remote light request.
// The optional ACK/NAK reply path is compiled in when BT_CMD_ACK_EN is defined.
module bt_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         MAX_LEN        = 8,
    parameter int         TIMEOUT_CYC    = 2500000,
    parameter logic [7:0] HEART_CAP_INIT = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] rx_byte,
    output logic [7:0] heart_cap,
    output logic [2:0] light_ctrl,
    output logic       cmd_strobe,
    output logic [7:0] cmd_code,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       is_transmitting
);

    localparam int         TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t        state;
    logic [7:0]    cmd_r;
    logic [7:0]    sum;
    logic [3:0]    len_r;
    logic [3:0]    idx;
    // Only the first payload byte drives any register, so only it is kept.
    logic [7:0]    pay0;
    logic [TW-1:0] tmo_cnt;
    logic          chk_err;

    logic [7:0]    chk_sum;
    logic          len_bad;
    logic          chk_bad;
    logic          tmo_hit;
    logic          err_evt;

    // Error conditions for the current cycle; a received byte always beats a timeout.
    always_comb begin
        chk_sum = sum + rx_byte;
        len_bad = received && (state == S_LEN) && (rx_byte > MAX_LEN_B);
        chk_bad = received && (state == S_CHK) && (chk_sum != 8'd0);
        tmo_hit = !received && (state != S_HUNT) && (tmo_cnt == TMO_LAST);
        err_evt = len_bad || chk_bad || tmo_hit;
    end

    // Frame parser FSM with registered command outputs and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HUNT;
            cmd_r      <= 8'd0;
            sum        <= 8'd0;
            len_r      <= 4'd0;
            idx        <= 4'd0;
            pay0       <= 8'd0;
            tmo_cnt    <= '0;
            chk_err    <= 1'b0;
            heart_cap  <= HEART_CAP_INIT;
            light_ctrl <= 3'd0;
            cmd_strobe <= 1'b0;
            cmd_code   <= 8'd0;
            frame_err  <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            cmd_strobe <= 1'b0;
            frame_err  <= err_evt;
            chk_err    <= chk_bad;
            if (err_evt && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            if (received) begin
                tmo_cnt <= '0;
                case (state)
                    S_HUNT: begin
                        if (rx_byte == SYNC_BYTE)
                            state <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_r <= rx_byte;
                        sum   <= rx_byte;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            state <= S_HUNT;
                        end else begin
                            sum   <= chk_sum;
                            len_r <= rx_byte[3:0];
                            idx   <= 4'd0;
                            state <= (rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (idx == 4'd0)
                            pay0 <= rx_byte;
                        sum <= chk_sum;
                        idx <= idx + 4'd1;
                        if (idx + 4'd1 == len_r)
                            state <= S_CHK;
                    end
                    S_CHK: begin
                        state <= S_HUNT;
                        if (!chk_bad) begin
                            cmd_strobe <= 1'b1;
                            cmd_code   <= cmd_r;
                            if (cmd_r == 8'h01 && len_r == 4'd1)
                                heart_cap <= pay0;
                            if (cmd_r == 8'h02 && len_r == 4'd1)
                                light_ctrl <= pay0[2:0];
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end else if (state != S_HUNT) begin
                if (tmo_hit) begin
                    state   <= S_HUNT;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BT_CMD_ACK_EN
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    logic       pend;
    logic [7:0] pend_byte;

    // One-entry reply queue: latest ACK/NAK wins, drained when the UART is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_byte <= 8'd0;
            transmit  <= 1'b0;
            tx_byte   <= 8'd0;
        end else begin
            transmit <= 1'b0;
            if (pend && !is_transmitting) begin
                pend     <= 1'b0;
                transmit <= 1'b1;
                tx_byte  <= pend_byte;
            end
            if (cmd_strobe || chk_err) begin
                pend      <= 1'b1;
                pend_byte <= cmd_strobe ? ACK_BYTE : NAK_BYTE;
            end
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ^{is_transmitting, chk_err};
    assign transmit   = 1'b0;
    assign tx_byte    = 8'd0;
`endif

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Self-checking bench for bt_cmd_decoder: directed frames from the test plan
// plus randomized frames, scored against a frame-level reference model.
module tb_bt_cmd_decoder;

    localparam int T  = 200;
    localparam int ML = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       is_transmitting = 1'b0;
    logic [7:0] heart_cap;
    logic [2:0] light_ctrl;
    logic       cmd_strobe;
    logic [7:0] cmd_code;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       transmit;
    logic [7:0] tx_byte;

    always #5 clk = ~clk;

    bt_cmd_decoder #(
        .SYNC_BYTE(8'hAA), .MAX_LEN(ML), .TIMEOUT_CYC(T), .HEART_CAP_INIT(8'd200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
        .heart_cap(heart_cap), .light_ctrl(light_ctrl), .cmd_strobe(cmd_strobe),
        .cmd_code(cmd_code), .frame_err(frame_err), .err_cnt(err_cnt),
        .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting)
    );

    typedef struct {
        bit         err;
        logic [7:0] cmd;
        logic [7:0] heart;
        logic [2:0] light;
        logic [7:0] ecnt;
    } exp_t;

    exp_t       evq[$];
    logic [7:0] txq[$];
    int         errors = 0;
    int         checks = 0;

    // Reference model state: what the phone-visible registers should hold.
    logic [7:0] m_heart = 8'd200;
    logic [7:0] m_cmd   = 8'd0;
    logic [2:0] m_light = 3'd0;
    logic [7:0] m_ecnt  = 8'd0;
    bit         tx_hold = 1'b0;
    bit         tx_pend_v = 1'b0;
    logic [7:0] tx_pend = 8'd0;
    logic [7:0] pl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input bit err);
        exp_t e;
        if (err && m_ecnt != 8'd255) m_ecnt = m_ecnt + 8'd1;
        e.err = err; e.cmd = m_cmd; e.heart = m_heart; e.light = m_light; e.ecnt = m_ecnt;
        evq.push_back(e);
    endtask

    task automatic note_tx(input logic [7:0] b);
`ifdef BT_CMD_ACK_EN
        if (tx_hold) begin tx_pend = b; tx_pend_v = 1'b1; end
        else txq.push_back(b);
`else
        if (b == 8'hFF) tx_pend = b;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic gap();
        idle($urandom_range(0, 2));
    endtask

    // Send one frame; delta != 0 corrupts the checksum by that amount.
    task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] delta);
        logic [7:0] s;
        logic [7:0] lb;
        lb = 8'(len);
        send_byte(8'hAA); gap();
        send_byte(cmd); gap();
        if (len > ML) begin
            push_evt(1'b1);
            send_byte(lb);
            return;
        end
        send_byte(lb);
        s = cmd + lb;
        for (int i = 0; i < len; i++) begin
            gap();
            send_byte(pl[i]);
            s = s + pl[i];
        end
        gap();
        if (delta != 8'd0) begin
            push_evt(1'b1);
            note_tx(8'h15);
        end else begin
            m_cmd = cmd;
            if (cmd == 8'h01 && len == 1) m_heart = pl[0];
            if (cmd == 8'h02 && len == 1) m_light = pl[0][2:0];
            push_evt(1'b0);
            note_tx(8'h06);
        end
        send_byte(8'h00 - s + delta);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (evq.size() != 0 || txq.size() != 0); i++)
            @(negedge clk);
        check("drain", evq.size() + txq.size(), 0);
    endtask

    // Monitor: every strobe/error pulse is matched against the scoreboard.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_strobe && frame_err) begin
                checks++; errors++;
                $display("FAIL exclusive: cmd_strobe and frame_err both 1");
            end else if (cmd_strobe || frame_err) begin
                if (evq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_evt: strobe=%0b err=%0b, none expected", cmd_strobe, frame_err);
                end else begin
                    me = evq.pop_front();
                    check("evt_is_err", frame_err, me.err);
                    check("cmd_code", cmd_code, me.cmd);
                    check("heart_cap", heart_cap, me.heart);
                    check("light_ctrl", light_ctrl, me.light);
                    check("err_cnt", err_cnt, me.ecnt);
                end
            end
            if (transmit) begin
`ifdef BT_CMD_ACK_EN
                if (txq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx: tx_byte=%0h, none expected", tx_byte);
                end else begin
                    check("tx_byte", tx_byte, txq.pop_front());
                end
`else
                check("transmit_off", transmit, 1'b0);
`endif
            end
        end
    end

    initial begin
        int len;
        int r;
        logic [7:0] cmd;
        logic [7:0] d;

        // Reset values
        idle(3);
        check("rst_heart", heart_cap, 8'd200);
        check("rst_light", light_ctrl, 3'd0);
        check("rst_cmd", cmd_code, 8'd0);
        check("rst_errcnt", err_cnt, 8'd0);
        check("rst_strobe", cmd_strobe, 1'b0);
        check("rst_tx", {transmit, tx_byte}, 9'd0);
        rst_n = 1'b1;
        idle(2);

        // AA 01 01 B4 4A -> heart_cap 0xB4
        pl[0] = 8'hB4;
        send_frame(8'h01, 1, 8'h00);
        idle(4);
        check("dir_heart_b4", heart_cap, 8'hB4);
        check("dir_cmd_01", cmd_code, 8'h01);

        // AA 02 01 05 F8 -> light 101, then ping AA 03 00 FD
        pl[0] = 8'h05;
        send_frame(8'h02, 1, 8'h00);
        send_frame(8'h03, 0, 8'h00);
        idle(4);
        check("dir_light_5", light_ctrl, 3'b101);
        check("dir_cmd_03", cmd_code, 8'h03);

        // Ping (ACK pending) then AA 01 01 B4 00 checksum error while UART busy:
        // NAK overwrites the pending ACK and goes out after the UART frees.
        is_transmitting = 1'b1;
        tx_hold = 1'b1;
        send_frame(8'h03, 0, 8'h00);
        pl[0] = 8'hB4;
        send_frame(8'h01, 1, 8'hB6);
        idle(6);
        check("dir_errcnt_1", err_cnt, 8'd1);
        tx_hold = 1'b0;
        if (tx_pend_v) begin txq.push_back(tx_pend); tx_pend_v = 1'b0; end
        is_transmitting = 1'b0;
        idle(6);

        // AA 01 09 length error, then AA 01 01 64 9A -> heart_cap 100
        send_frame(8'h01, 9, 8'h00);
        pl[0] = 8'h64;
        send_frame(8'h01, 1, 8'h00);
        idle(4);
        check("dir_heart_100", heart_cap, 8'd100);
        check("dir_errcnt_2", err_cnt, 8'd2);

        // Timeout: AA 01 then T idle cycles
        send_byte(8'hAA);
        send_byte(8'h01);
        push_evt(1'b1);
        idle(T + 3);
        pl[0] = 8'h8C;
        send_frame(8'h01, 1, 8'h00);
        // Long idle in HUNT must not count
        idle(T + 20);

        // Byte arriving exactly at expiry on every step: no error
        send_byte(8'hAA);
        send_byte(8'h02);
        idle(T - 1);
        send_byte(8'h01);
        idle(T - 1);
        send_byte(8'h03);
        idle(T - 1);
        m_cmd = 8'h02; m_light = 3'b011;
        push_evt(1'b0);
        note_tx(8'h06);
        send_byte(8'hFA);
        idle(4);
        check("expiry_light", light_ctrl, 3'b011);
        drain();

        // Randomized frames with garbage between them
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 2);
            for (int g = 0; g < r; g++) begin
                d = 8'($urandom_range(0, 255));
                if (d == 8'hAA) d = 8'h55;
                send_byte(d);
            end
            r = $urandom_range(0, 3);
            cmd = (r == 3) ? 8'($urandom_range(0, 255)) : 8'(r + 1);
            len = $urandom_range(0, ML + 1);
            if ($urandom_range(0, 1) == 1) len = 1;
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
            d = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(cmd, len, d);
            gap();
        end
        drain();

        // Mid-frame reset after making heart/light non-default
        pl[0] = 8'h33; send_frame(8'h01, 1, 8'h00);
        pl[0] = 8'h06; send_frame(8'h02, 1, 8'h00);
        drain();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_heart", heart_cap, 8'd200);
        check("mid_rst_light", light_ctrl, 3'd0);
        check("mid_rst_errcnt", err_cnt, 8'd0);
        check("mid_rst_cmd", cmd_code, 8'd0);
        m_heart = 8'd200; m_light = 3'd0; m_cmd = 8'd0; m_ecnt = 8'd0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 256 bad-checksum frames saturate err_cnt at 255
        for (int f = 0; f < 256; f++) begin
            pl[0] = 8'($urandom_range(0, 255));
            send_frame(8'h01, 1, 8'($urandom_range(1, 255)));
            idle(2);
        end
        idle(4);
        check("sat_errcnt", err_cnt, 8'd255);
        check("sat_heart", heart_cap, 8'd200);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
